axis_fifo: RTL and testbench

Parametrised synchronous AXI4-Stream FIFO carrying the full sideband set (tdata, tstrb, tkeep, tlast, tid, tdest, tuser) at configurable widths, with tid at TID_BITS width. It decouples producer and consumer stream stages in the same clock domain and provides an occupancy count. An optional packet mode holds output until a complete tlast-terminated packet is stored.

---
 rtl/axis_fifo_pkg.sv | 13 +
 rtl/axis_fifo_mem.sv | 26 ++
 rtl/axis_fifo.sv | 153 +++++++++++++++
 tb/tb_axis_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers for the AXI4-Stream FIFO.
package axis_fifo_pkg;

    // Pointers and the occupancy count carry one extra bit so that full and empty differ.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_is_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Entry storage for axis_fifo: one synchronous write port, one asynchronous read port.
module axis_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage is deliberately left out of reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_fifo.sv
// Synchronous first-word-fall-through AXI4-Stream FIFO with registered s_axis_tready and count.
// Define AXIS_FIFO_PACKET_MODE_EN to hold output until a complete tlast-terminated packet is stored.
module axis_fifo
    import axis_fifo_pkg::*;
#(
    parameter int TDATA_BYTES = 4,
    parameter int TID_BITS    = 1,
    parameter int TDEST_BITS  = 1,
    parameter int TUSER_BITS  = 1,
    parameter int DEPTH       = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    input  logic [8*TDATA_BYTES-1:0]         s_axis_tdata,
    input  logic [TDATA_BYTES-1:0]           s_axis_tstrb,
    input  logic [TDATA_BYTES-1:0]           s_axis_tkeep,
    input  logic                             s_axis_tlast,
    input  logic [TID_BITS-1:0]              s_axis_tid,
    input  logic [TDEST_BITS-1:0]            s_axis_tdest,
    input  logic [TUSER_BITS-1:0]            s_axis_tuser,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [8*TDATA_BYTES-1:0]         m_axis_tdata,
    output logic [TDATA_BYTES-1:0]           m_axis_tstrb,
    output logic [TDATA_BYTES-1:0]           m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic [TID_BITS-1:0]              m_axis_tid,
    output logic [TDEST_BITS-1:0]            m_axis_tdest,
    output logic [TUSER_BITS-1:0]            m_axis_tuser,
    output logic [cnt_width(DEPTH)-1:0]      count
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 8*TDATA_BYTES + 2*TDATA_BYTES + 1 + TID_BITS + TDEST_BITS + TUSER_BITS;

    if (!depth_is_legal(DEPTH)) begin : g_depth_check
        $error("axis_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid;
    logic          wr_en, rd_en;
    logic [PW-1:0] wr_payload, rd_payload, out_payload;

    function automatic logic is_full(input logic [CW-1:0] w, input logic [CW-1:0] r);
        return (w[CW-1] != r[CW-1]) && (w[CW-2:0] == r[CW-2:0]);
    endfunction

    assign wr_en = s_axis_tvalid && s_ready_q;
    assign rd_en = m_valid && m_axis_tready;

    // NOTE: every variable gets a default first so no path through the block can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + CW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + CW'(1);
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Ready looks at post-update pointers only, so a read from full frees space one cycle later.
        s_ready_d = !is_full(wr_ptr_d, rd_ptr_d);
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            s_ready_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            s_ready_q <= s_ready_d;
        end
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    localparam int LAST_POS = TID_BITS + TDEST_BITS + TUSER_BITS;

    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          flush_q, flush_d;
    logic          head_last;

    assign head_last = rd_payload[LAST_POS];

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        flush_d   = flush_q;
        unique case ({wr_en && s_axis_tlast, rd_en && head_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        // A full FIFO with no tlast stored can never complete a packet; drain it to break the deadlock.
        if (rd_en && head_last) begin
            flush_d = 1'b0;
        end else if (is_full(wr_ptr_q, rd_ptr_q) && (pkt_cnt_q == '0)) begin
            flush_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            flush_q   <= flush_d;
        end
    end

    assign m_valid = (wr_ptr_q != rd_ptr_q) && ((pkt_cnt_q != '0) || flush_q);
`else
    assign m_valid = (wr_ptr_q != rd_ptr_q);
`endif

    assign wr_payload = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                         s_axis_tid, s_axis_tdest, s_axis_tuser};

    axis_fifo_mem #(
        .WIDTH (PW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (aclk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_payload),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_payload)
    );

    assign out_payload = m_valid ? rd_payload : '0;
    assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
            m_axis_tid, m_axis_tdest, m_axis_tuser} = out_payload;

    assign m_axis_tvalid = m_valid;
    assign s_axis_tready = s_ready_q;
    assign count         = count_q;

endmodule

// File: tb/tb_axis_fifo.sv
// Self-checking bench for axis_fifo (DEPTH=4): directed steps plus random traffic against a queue model.
module tb_axis_fifo;

    localparam int DEPTH = 4;
    localparam int TB    = 4;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic        id;
        logic        dest;
        logic        user;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;
    beat_t       s_beat = '0;
    logic        s_axis_tready, m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tstrb, m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser;
    logic [2:0]  count;
    beat_t       m_beat;

    always #5 aclk = ~aclk;

    axis_fifo #(
        .TDATA_BYTES (TB),
        .TID_BITS    (1),
        .TDEST_BITS  (1),
        .TUSER_BITS  (1),
        .DEPTH       (DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_beat.data),
        .s_axis_tstrb  (s_beat.strb),
        .s_axis_tkeep  (s_beat.keep),
        .s_axis_tlast  (s_beat.last),
        .s_axis_tid    (s_beat.id),
        .s_axis_tdest  (s_beat.dest),
        .s_axis_tuser  (s_beat.user),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tuser  (m_axis_tuser),
        .count         (count)
    );

    assign m_beat = '{m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
                      m_axis_tid, m_axis_tdest, m_axis_tuser};

    // Reference model: the FIFO contents as a queue, plus the flush flag and registered ready.
    beat_t q[$];
    bit    flush_m = 1'b0;
    bit    tready_m = 1'b0;
    int    popped = 0;
    int    total = 0;
    int    bad = 0;

    function automatic int nlast();
        int n = 0;
        foreach (q[i]) if (q[i].last) n++;
        return n;
    endfunction

    function automatic bit mvalid_m();
        return (q.size() != 0) && (!PKT || nlast() != 0 || flush_m);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit mv;
        mv = mvalid_m();
        check({tag, ".s_tready"}, 64'(s_axis_tready), 64'(tready_m));
        check({tag, ".m_tvalid"}, 64'(m_axis_tvalid), 64'(mv));
        check({tag, ".count"}, 64'(count), 64'(q.size()));
        check({tag, ".payload"}, 64'(m_beat), mv ? 64'(q[0]) : 64'(0));
    endtask

    // One clock: compare outputs, advance the DUT and the model together.
    task automatic cycle(input string tag);
        bit wr, rd, rd_last, full_nolast;
        #1;
        check_outputs(tag);
        wr          = s_valid && tready_m;
        rd          = mvalid_m() && m_ready;
        rd_last     = rd && q[0].last;
        full_nolast = (q.size() == DEPTH) && (nlast() == 0);
        @(posedge aclk);
        #1;
        if (rd) begin
            void'(q.pop_front());
            popped++;
        end
        if (wr) q.push_back(s_beat);
        if (rd_last) flush_m = 1'b0;
        else if (full_nolast) flush_m = 1'b1;
        tready_m = (q.size() != DEPTH);
    endtask

    function automatic beat_t rand_beat(input int last_pct);
        beat_t b;
        b.data = $urandom;
        b.strb = 4'($urandom);
        b.keep = 4'($urandom);
        b.last = ($urandom_range(0, 99) < last_pct);
        b.id   = 1'($urandom);
        b.dest = 1'($urandom);
        b.user = 1'($urandom);
        return b;
    endfunction

    // Push an n-beat packet (tlast on the final beat) with m_ready held high, then drain it.
    task automatic send_packet(input string tag, input int n);
        int idx = 0;
        int start = popped;
        m_ready = 1'b1;
        for (int c = 0; c < 40 && idx < n; c++) begin
            s_beat      = rand_beat(0);
            s_beat.last = (idx == n - 1);
            s_valid     = 1'b1;
            if (tready_m) idx++;
            cycle(tag);
        end
        s_valid = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0; c++) cycle(tag);
        check({tag, ".accepted"}, 64'(idx), 64'(n));
        check({tag, ".delivered"}, 64'(popped - start), 64'(n));
    endtask

    initial begin
        // Reset state, then ready rises after the first edge past release.
        #2;
        check_outputs("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        check_outputs("release");
        cycle("first_edge");
        check("first_edge.ready_up", 64'(s_axis_tready), 64'(1));

        // Fill to full with the consumer stalled, then drain in order.
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            s_beat      = rand_beat(0);
            s_beat.data = 32'h1111_1111 * (i + 1);
            s_beat.last = 1'b1;
            s_valid     = 1'b1;
            cycle("fill");
        end
        s_valid = 1'b0;
        #1;
        check("fill.count4", 64'(count), 64'(4));
        check("fill.ready0", 64'(s_axis_tready), 64'(0));
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("drain.data", 64'(m_axis_tdata), 64'(32'h1111_1111 * (i + 1)));
            check("drain.count", 64'(count), 64'(DEPTH - i));
            cycle("drain");
        end
        check("drain.empty", 64'(count), 64'(0));

        // Hold two entries, then stream in and out simultaneously for 8 cycles.
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_beat = rand_beat(100);
            s_valid = 1'b1;
            cycle("prime");
        end
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_beat = rand_beat(100);
            cycle("stream");
        end
        check("stream.count2", 64'(count), 64'(2));
        s_valid = 1'b0;
        for (int i = 0; i < 2; i++) cycle("stream_drain");

        // Every sideband field passes through untouched.
        m_ready = 1'b0;
        s_beat  = '{32'hCAFE_F00D, 4'h6, 4'hE, 1'b1, 1'b1, 1'b1, 1'b1};
        s_valid = 1'b1;
        cycle("side_wr");
        s_valid = 1'b0;
        #1;
        check("side.fields", 64'(m_beat), 64'({32'hCAFE_F00D, 4'h6, 4'hE, 4'hF}));
        m_ready = 1'b1;
        cycle("side_rd");

        // Packet boundaries: a normal packet and one larger than the FIFO.
        send_packet("pkt3", 3);
        send_packet("pkt5", 5);

        // Mid-stream reset with three entries stored.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_beat  = rand_beat(0);
            s_valid = 1'b1;
            cycle("pre_rst");
        end
        s_valid = 1'b0;
        #1;
        check("pre_rst.count3", 64'(count), 64'(3));
        #2;
        aresetn = 1'b0;
        #1;
        q.delete();
        flush_m  = 1'b0;
        tready_m = 1'b0;
        check_outputs("mid_rst");
        @(negedge aclk);
        aresetn = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle("post_rst");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            s_beat  = rand_beat(25);
            cycle("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
